fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
//  Read-side consumer for the Async_FIFO. Runs in the read clock domain and
//  pops fixed-length bursts of BURST_LEN words through rinc/rempty/rdata.
//  Words go out on a valid/ready stream through a 2-entry output buffer, so
//  it reaches full throughput and absorbs downstream back-pressure.
// PARAMETERS
//  DATA_LINES  8    width of FIFO rdata and out_data
//  BURST_LEN   16   words per burst, must be >= 1
//  CNT_W       $clog2(BURST_LEN+1)  width of the remaining-word counter
// PORTS
//  rclk        in   1           read-domain clock, rising edge
//  rrst        in   1           asynchronous active-low reset
//  start       in   1           burst request pulse, sampled in IDLE only
//  rempty      in   1           FIFO empty flag
//  rdata       in   DATA_LINES  FIFO head word, valid while rempty=0
//  rinc        out  1           FIFO pop strobe, combinational
//  out_data    out  DATA_LINES  stream data
//  out_valid   out  1           stream valid
//  out_ready   in   1           stream ready from downstream
//  out_last    out  1           marks the BURST_LEN-th word of a burst
//  busy        out  1           high whenever state != IDLE
//  burst_done  out  1           1-cycle pulse at burst completion
// BEHAVIOUR
//  - Reset: state=IDLE, buffer count=0, remaining=0. out_valid=0,
//    out_data=0, out_last=0, busy=0, burst_done=0, rinc=0.
//  - FSM IDLE->BURST: start=1 in IDLE loads remaining=BURST_LEN.
//    start in any other state is ignored.
//  - FSM BURST->FLUSH: taken on the rinc cycle that brings remaining to 0.
//  - FSM FLUSH->IDLE: taken when the buffer is empty.
//    burst_done=1 for exactly that one cycle.
//  - rinc = (state==BURST) & ~rempty & (remaining!=0) & (buf_cnt<2).
//    rinc is never high while rempty=1, so no underflow.
//  - On a rinc cycle, rdata and the tag (remaining==1) are written into the
//    buffer at the rclk edge. out_valid rises on the next cycle: 1-cycle
//    latency from pop to stream.
//  - Handshake: a word transfers when out_valid & out_ready.
//    While out_valid=1 and out_ready=0, out_data and out_last stay stable.
//    Words are never dropped or duplicated; order is FIFO order.
//  - Simultaneous push and pop with buf_cnt==1: buf_cnt stays 1.
//    With out_ready held high this gives one word per cycle.
//  - buf_cnt==2: rinc is held low until a handshake frees an entry.
//  - FIFO empty mid-burst: stays in BURST, busy=1, resumes when rempty=0.
//    There is no timeout.
//  - out_last is high only with the tagged word. Exactly one per burst.
//  - remaining is unsigned, CNT_W bits, decrements by 1 per rinc, and
//    never wraps below 0.
//  - Reset mid-operation: returns to reset values. Buffered words are
//    discarded; words already popped from the FIFO are lost.
// CONFIGURATION
//  FIFO_RD_STATS_EN defined: adds output rd_words [31:0].
//   - Increments by 1 on each out_valid & out_ready handshake.
//   - Saturates at 32'hFFFF_FFFF.
//   - Cleared only by rrst.
//  FIFO_RD_STATS_EN undefined: no rd_words port, no counter logic.
//   All other behaviour is identical with and without the macro.
// TESTING
//  T1 Full-rate burst: FIFO preloaded 0x00..0x0F, out_ready=1, start pulse.
//     -> rinc high 16 consecutive cycles.
//     -> out_data 0x00..0x0F on 16 consecutive cycles, out_last only on 0x0F.
//     -> burst_done 1 cycle after the last handshake; busy then 0.
//  T2 Back-pressure: out_ready=0 from start, FIFO holds 16 words.
//     -> exactly 2 rinc pulses, then rinc=0.
//     -> out_valid=1 with out_data=0x00 held stable.
//     -> release out_ready: the remaining 14 words follow, none lost or duplicated.
//  T3 FIFO starves: 5 words, then rempty=1 for 10 cycles, then 11 more words.
//     -> rinc=0 throughout the empty gap, busy=1.
//     -> 16 words delivered in total, out_last on the 16th.
//  T4 Ignored requests:
//     -> start pulsed mid-burst has no effect (still 16 words, one burst_done).
//     -> start in IDLE with rempty=1 held: rinc never asserts, busy=1.
//  T5 Reset mid-burst after 7 handshakes:
//     -> all outputs at reset values next cycle.
//     -> a new start pops a fresh 16-word burst.
//  T6 FIFO_RD_STATS_EN defined: two full bursts -> rd_words=32.
//     -> rrst asserted -> rd_words=0.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side consumer for the asynchronous FIFO.
// Pops fixed-length bursts of BURST_LEN words through rinc/rempty/rdata and
// streams them out on a valid/ready interface through a 2-entry buffer.
// Optional feature: define FIFO_RD_STATS_EN to add the rd_words handshake
// counter output.

module fifo_burst_reader #(
  parameter int DATA_LINES = 8,
  parameter int BURST_LEN  = 16,
  parameter int CNT_W      = $clog2(BURST_LEN + 1)
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  start,
  input  logic                  rempty,
  input  logic [DATA_LINES-1:0] rdata,
  output logic                  rinc,
  output logic [DATA_LINES-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
`ifdef FIFO_RD_STATS_EN
  output logic                  burst_done,
  output logic [31:0]           rd_words
`else
  output logic                  burst_done
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      remaining_q;
  logic [1:0]            buf_cnt;
  logic [DATA_LINES-1:0] buf_data [2];
  logic                  buf_last [2];
  logic                  push;
  logic                  pop;
  logic                  push_last;

  // Pop strobe and stream handshake, both purely combinational.
  always_comb begin
    rinc      = (state_q == BURST) && !rempty && (remaining_q != '0) &&
                (buf_cnt < 2'd2);
    push      = rinc;
    push_last = (remaining_q == CNT_W'(1));
    out_valid = (buf_cnt != 2'd0);
    pop       = out_valid && out_ready;
    out_data  = buf_data[0];
    out_last  = out_valid && buf_last[0];
    busy      = (state_q != IDLE);
  end

  // Next-state logic and the one-cycle completion pulse.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d    = state_q;
    burst_done = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = BURST;
      BURST:   if (rinc && push_last) state_d = FLUSH;
      FLUSH: begin
        if (buf_cnt == 2'd0) begin
          state_d    = IDLE;
          burst_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge rclk or negedge rrst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    if (!rrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Remaining-word counter: loaded on burst start, decremented per pop.
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      remaining_q <= '0;
    end else if (state_q == IDLE && start) begin
      remaining_q <= CNT_W'(BURST_LEN);
    end else if (rinc) begin
      remaining_q <= remaining_q - CNT_W'(1);
    end
  end

  // Two-entry output buffer; slot 0 is always the head of the stream.
  always_ff @(posedge rclk or negedge rrst) begin
    // NOTE: the buffer storage is reset too, because out_data is driven
    // straight from slot 0 and must read zero out of reset; it is only two
    // words, so the reset cost is negligible.
    if (!rrst) begin
      buf_cnt     <= 2'd0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last[0] <= 1'b0;
      buf_last[1] <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            buf_data[0] <= rdata;
            buf_last[0] <= push_last;
          end else begin
            buf_data[1] <= rdata;
            buf_last[1] <= push_last;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf_data[0] <= buf_data[1];
          buf_last[0] <= buf_last[1];
          buf_cnt     <= buf_cnt - 2'd1;
        end
        2'b11: begin
          // Push needs buf_cnt<2 and pop needs buf_cnt>0, so buf_cnt is 1:
          // the new word replaces the departing head and the count holds.
          buf_data[0] <= rdata;
          buf_last[0] <= push_last;
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  // Saturating count of stream handshakes, cleared only by reset.
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      rd_words <= '0;
    end else if (pop && (rd_words != 32'hFFFF_FFFF)) begin
      rd_words <= rd_words + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a FIFO model feeds rdata/rempty,
// loads push expected words into a queue, and a monitor compares every
// presented stream word against the queue head.

module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int BL = 16;

  logic          rclk = 1'b0;
  logic          rrst = 1'b0;
  logic          start = 1'b0;
  logic          rempty = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic          out_ready = 1'b0;
  logic          rinc;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          burst_done;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]   rd_words;
`endif

  fifo_burst_reader #(.DATA_LINES(DW), .BURST_LEN(BL)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .start      (start),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
`ifdef FIFO_RD_STATS_EN
    .burst_done (burst_done),
    .rd_words   (rd_words)
`else
    .burst_done (burst_done)
`endif
  );

  always #5 rclk = ~rclk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fifo_q [$];
  logic [DW:0]   exp_q  [$];
  int            burst_pos = 0;

  // Monitor statistics, cleared on request from the stimulus process.
  int clr_req = 0;
  int rinc_cnt, rinc_run, rinc_max, hs_cnt, hs_run, hs_max, done_cnt, last_cnt;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: pop on a sampled rinc, present the new head after the edge.
  initial begin
    logic will_pop;
    forever begin
      @(negedge rclk);
      will_pop = rinc;
      @(posedge rclk);
      #1;
      if (will_pop) begin
        check("no_underflow", 32'(fifo_q.size() > 0), 32'd1);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      rempty = (fifo_q.size() == 0);
      rdata  = rempty ? '0 : fifo_q[0];
    end
  end

  // Monitor: compares every presented word against the scoreboard head.
  initial begin
    int clr_seen;
    clr_seen = 0;
    rinc_cnt = 0; rinc_run = 0; rinc_max = 0; hs_cnt = 0; hs_run = 0;
    hs_max = 0; done_cnt = 0; last_cnt = 0;
    forever begin
      @(negedge rclk);
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        rinc_cnt = 0; rinc_run = 0; rinc_max = 0; hs_cnt = 0; hs_run = 0;
        hs_max = 0; done_cnt = 0; last_cnt = 0;
      end
      if (rrst) begin
        if (rinc) check("rinc_while_empty", 32'(rempty), 32'd0);
        rinc_cnt += rinc ? 1 : 0;
        rinc_run  = rinc ? rinc_run + 1 : 0;
        if (rinc_run > rinc_max) rinc_max = rinc_run;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_word", 32'd1, 32'd0);
          end else begin
            check("out_data", 32'(out_data), 32'(exp_q[0][DW-1:0]));
            check("out_last", 32'(out_last), 32'(exp_q[0][DW]));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        hs_cnt += (out_valid && out_ready) ? 1 : 0;
        hs_run  = (out_valid && out_ready) ? hs_run + 1 : 0;
        if (hs_run > hs_max) hs_max = hs_run;
        done_cnt += burst_done ? 1 : 0;
        last_cnt += (out_valid && out_ready && out_last) ? 1 : 0;
      end
    end
  end

  task automatic tick();
    @(posedge rclk);
    #2;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_stats();
    clr_req++;
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = DW'(base + i);
      fifo_q.push_back(d);
      exp_q.push_back({burst_pos == BL - 1, d});
      burst_pos = (burst_pos + 1) % BL;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!burst_done && k < budget) begin
      @(negedge rclk);
      #1;
      k++;
    end
    check("burst_done_seen", 32'(burst_done), 32'd1);
    tick();
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_burst_done", 32'(burst_done), 32'd0);
    check("rst_rinc", 32'(rinc), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_reset_outputs();
    wait_cycles(2);
    rrst = 1'b1;
    tick();

    // T1: full-rate burst with the FIFO preloaded.
    clear_stats();
    out_ready = 1'b1;
    load(16, 8'h00);
    tick();
    pulse_start();
    wait_done(100);
    check("t1_rinc_total", rinc_cnt, 16);
    check("t1_rinc_run", rinc_max, 16);
    check("t1_hs_total", hs_cnt, 16);
    check("t1_hs_run", hs_max, 16);
    check("t1_last_cnt", last_cnt, 1);
    check("t1_done_cnt", done_cnt, 1);

    // T2: back-pressure from the start of the burst.
    clear_stats();
    out_ready = 1'b0;
    load(16, 8'h40);
    tick();
    pulse_start();
    wait_cycles(10);
    check("t2_rinc_stalled", rinc_cnt, 2);
    check("t2_rinc_low", 32'(rinc), 32'd0);
    check("t2_valid_held", 32'(out_valid), 32'd1);
    check("t2_data_held", 32'(out_data), 32'h40);
    out_ready = 1'b1;
    wait_done(100);
    check("t2_hs_total", hs_cnt, 16);
    check("t2_rinc_total", rinc_cnt, 16);
    check("t2_last_cnt", last_cnt, 1);

    // T3: FIFO runs dry mid-burst, then refills.
    clear_stats();
    load(5, 8'h80);
    tick();
    pulse_start();
    wait_cycles(8);
    check("t3_rinc_before_gap", rinc_cnt, 5);
    wait_cycles(10);
    check("t3_rinc_in_gap", rinc_cnt, 5);
    check("t3_busy_in_gap", 32'(busy), 32'd1);
    check("t3_hs_in_gap", hs_cnt, 5);
    load(11, 8'h85);
    wait_done(100);
    check("t3_hs_total", hs_cnt, 16);
    check("t3_last_cnt", last_cnt, 1);
    check("t3_done_cnt", done_cnt, 1);

    // T4a: start pulsed mid-burst is ignored.
    clear_stats();
    load(16, 8'hA0);
    tick();
    pulse_start();
    wait_cycles(4);
    pulse_start();
    wait_done(100);
    wait_cycles(20);
    check("t4_hs_total", hs_cnt, 16);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_rinc_total", rinc_cnt, 16);
    check("t4_idle_busy", 32'(busy), 32'd0);

    // T4b: start with an empty FIFO waits without popping.
    clear_stats();
    pulse_start();
    wait_cycles(10);
    check("t4b_rinc_none", rinc_cnt, 0);
    check("t4b_busy", 32'(busy), 32'd1);
    load(16, 8'hC0);
    wait_done(100);
    check("t4b_hs_total", hs_cnt, 16);

    // T5: reset mid-burst after 7 handshakes, then a fresh burst.
    clear_stats();
    load(16, 8'h10);
    tick();
    pulse_start();
    begin
      int k;
      k = 0;
      while (hs_cnt < 7 && k < 60) begin
        @(negedge rclk);
        #1;
        k++;
      end
      check("t5_reached_7", 32'(hs_cnt >= 7), 32'd1);
    end
    rrst = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    fifo_q.delete();
    exp_q.delete();
    burst_pos = 0;
    tick();
    check_reset_outputs();
    rrst = 1'b1;
    tick();
    clear_stats();
    load(16, 8'h30);
    tick();
    pulse_start();
    wait_done(100);
    check("t5_hs_total", hs_cnt, 16);
    check("t5_last_cnt", last_cnt, 1);

`ifdef FIFO_RD_STATS_EN
    // T6: handshake counter over two bursts, cleared by reset.
    rrst = 1'b0;
    tick();
    check("t6_cnt_reset", rd_words, 32'd0);
    rrst = 1'b1;
    tick();
    load(16, 8'h00);
    tick();
    pulse_start();
    wait_done(100);
    load(16, 8'h10);
    tick();
    pulse_start();
    wait_done(100);
    check("t6_rd_words", rd_words, 32'd32);
    rrst = 1'b0;
    #1;
    check("t6_cnt_cleared", rd_words, 32'd0);
    tick();
    rrst = 1'b1;
    tick();
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
